seg_display_arbiter: RTL and testbench
======================================

# seg_display_arbiter

Shares the board's 4-digit seven-segment display among up to NREQ client modules (game screens, score counters, debug readouts) and drives the multiplexed anode/segment scan itself. Round-robin arbitration with a minimum hold time; ownership changes only at scan-frame boundaries so no frame ever mixes two clients' data. It sits between the client modules and the top-level `an`/`seg` pins and replaces per-client digit drivers.

## Interface
- `NREQ`, 3: number of requesters, 2..8.
- `SCAN_DIV`, 100000: clk cycles per digit slot, ≥2.
- `MIN_HOLD`, 64: frames an owner keeps the display before it can be preempted by a waiting requester, ≥1.
- `clk`  in  1  system clock; all logic on posedge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  NREQ  per-client display request, level-sensitive.
- `data`  in  16*NREQ  client i's value at bits [16i+15:16i]; nibble k drives digit k (k=0 rightmost).
- `gnt`  out  NREQ  one-hot current owner; all-zero when idle.
- `an`  out  4  anodes, active-low.
- `seg`  out  7  segments {g..a}, active-low.

## Operation
- Scan: `div` counts 0..SCAN_DIV-1; at `div==SCAN_DIV-1`, `dig` (2 bits) increments, wrapping 3→0. Frame boundary `fb` = `div==SCAN_DIV-1 && dig==3`.
- FSM states IDLE, OWN; `owner` index, `rr` pointer, `hold` counter (saturates at MIN_HOLD). All transitions only on `fb`.
- IDLE on `fb`: if any `req`, owner = first set requester searching from `rr` upward with wrap; `hold`=0; → OWN. Else stay.
- OWN on `fb`, in priority order:
  - `req[owner]`==0: owner = next set requester after owner (owner excluded); none → IDLE.
  - `hold`≥MIN_HOLD and another requester set: owner = next set requester after owner; `hold`=0.
  - else `hold` += 1 (saturating).
- On every new grant `rr` = owner+1 mod NREQ.
- `gnt` = one-hot(owner) in OWN, 0 in IDLE.
- Display in OWN: `an` = ~(1<<dig); `seg` = hex decode of owner's nibble `dig` (0-9, A b C d E F). IDLE: `an`=4'hF, `seg`=7'h7F.
- Data is sampled live each cycle (no latching); clients keep `data` stable while granted.
- `req` dropped mid-frame: display keeps showing that client until `fb`.

## Timing
- Reset (async assert): `an`=4'hF, `seg`=7'h7F, `gnt`=0, `div`=0, `dig`=0, state IDLE, `rr`=0, `hold`=0.
- `gnt`, state, `owner` update in the cycle following `fb` (registered on the `fb` edge).
- `an`/`seg` registered: reflect `dig`/owner of the previous cycle (1-cycle latency). First lit anode after grant = `an`=4'b1110, one cycle after `gnt` rises.
- Request latency: IDLE grant at next `fb`, worst case 4*SCAN_DIV cycles.
- Simultaneous drop-by-owner and new requests at `fb`: handled in the same `fb` (no idle frame).
- Reset mid-frame: outputs blank immediately; scan restarts at digit 0.

## Configuration
- `SEG_BLANK_LEADING_EN` defined: leading-zero blanking — digits above the most significant nonzero nibble show `seg`=7'h7F (anode still scans); digit 0 always shown, so 0x0000 displays "0".
- Not defined: all four digits always shown (0x0042 → "0042").

## Test plan
Bench uses SCAN_DIV=4, MIN_HOLD=2 (frame = 16 cycles).
- Reset then `req`=3'b010, data1=16'h12AF → `gnt`=3'b010 after first `fb`; scan `an` 1110,1101,1011,0111 each held 4 cycles with `seg` F,A,2,1 patterns (7'h0E,7'h08,7'h24,7'h79).
- `req`=3'b111 from IDLE, rr=0 → owner 0; after 2 frames held owner rotates to 1 at 3rd `fb`, then 2, then 0.
- Owner 1 drops `req` mid-frame with `req[2]` set → display shows client 1 to end of frame, `gnt`=3'b100 after `fb`, no blank frame.
- Sole owner drops `req` → IDLE after `fb`; `an`=4'hF, `seg`=7'h7F, `gnt`=0.
- `rst_n` low mid-scan for 1 cycle → outputs blank asynchronously; after release, `div`=`dig`=0, new grant at first `fb`.
- data=16'h0042: with `SEG_BLANK_LEADING_EN` digits 3,2 blank, 1,0 show "42"; without, shows "0042".

Source files
------------

// File: rtl/seg_display_arbiter_if.sv
// ============================================================================
// Module      : seg_display_arbiter_if
// Description : Client request/data bus plus anode/segment display pins
//               shared by the seven-segment display arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seg_display_arbiter_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]    req;
    logic [16*NREQ-1:0] data;
    logic [NREQ-1:0]    gnt;
    logic [3:0]         an;
    logic [6:0]         seg;

    // Client side: raises requests, supplies digits, watches grant and pins.
    modport master (
        output req,
        output data,
        input  gnt,
        input  an,
        input  seg
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  data,
        output gnt,
        output an,
        output seg
    );
endinterface

`default_nettype wire

// File: rtl/seg_display_arbiter.sv
// ============================================================================
// Module      : seg_display_arbiter
// Description : Round-robin owner of a 4-digit multiplexed seven-segment
//               display; ownership changes only on scan-frame boundaries.
//               Optional macro SEG_BLANK_LEADING_EN enables leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_display_arbiter #(
    parameter int NREQ     = 3,
    parameter int SCAN_DIV = 100000,
    parameter int MIN_HOLD = 64
) (
    input  wire                   clk,
    input  wire                   rst_n,
    seg_display_arbiter_if.slave  bus
);

    localparam int OW = $clog2(NREQ);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int HW = $clog2(MIN_HOLD + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   rr_q,    rr_d;
    logic [HW-1:0]   hold_q,  hold_d;
    logic [DW-1:0]   div_q;
    logic [1:0]      dig_q;
    logic [3:0]      an_q,  an_d;
    logic [6:0]      seg_q, seg_d;

    logic            w_div_end;
    logic            w_fb;
    logic [OW:0]     w_first;
    logic [OW:0]     w_next;
    logic [15:0]     w_word;
    logic [3:0]      w_nib;
    logic            w_blank;

    function automatic logic [OW-1:0] inc_mod(input logic [OW-1:0] v);
        return (v == OW'(NREQ - 1)) ? '0 : v + 1'b1;
    endfunction

    // {found, index} of the first set request among `span` slots from `start`, wrapping.
    function automatic logic [OW:0] find_req(input logic [NREQ-1:0] r,
                                             input logic [OW-1:0]   start,
                                             input int              span);
        logic [OW:0] res;
        int          j;
        res = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = int'(start) + i;
            if (j >= NREQ) j = j - NREQ;
            if (i < span && r[j]) res = {1'b1, OW'(j)};
        end
        return res;
    endfunction

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    assign w_div_end = (div_q == DW'(SCAN_DIV - 1));
    assign w_fb      = w_div_end && (dig_q == 2'd3);
    assign w_first   = find_req(bus.req, rr_q, NREQ);
    assign w_next    = find_req(bus.req, inc_mod(owner_q), NREQ - 1);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        hold_d  = hold_q;
        if (w_fb) begin
            case (state_q)
                S_IDLE: begin
                    if (w_first[OW]) begin
                        state_d = S_OWN;
                        owner_d = w_first[OW-1:0];
                        rr_d    = inc_mod(w_first[OW-1:0]);
                        hold_d  = '0;
                    end
                end
                default: begin
                    if (!bus.req[owner_q]) begin
                        if (w_next[OW]) begin
                            owner_d = w_next[OW-1:0];
                            rr_d    = inc_mod(w_next[OW-1:0]);
                            hold_d  = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else if (hold_q >= HW'(MIN_HOLD) && w_next[OW]) begin
                        owner_d = w_next[OW-1:0];
                        rr_d    = inc_mod(w_next[OW-1:0]);
                        hold_d  = '0;
                    end else if (hold_q < HW'(MIN_HOLD)) begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign w_word = bus.data[int'(owner_q)*16 +: 16];
    assign w_nib  = w_word[int'(dig_q)*4 +: 4];

`ifdef SEG_BLANK_LEADING_EN
    // Digit 0 is never blanked so an all-zero value still shows "0".
    always_comb begin
        case (dig_q)
            2'd3:    w_blank = (w_word[15:12] == 4'h0);
            2'd2:    w_blank = (w_word[15:8]  == 8'h00);
            2'd1:    w_blank = (w_word[15:4]  == 12'h000);
            default: w_blank = 1'b0;
        endcase
    end
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        an_d  = 4'hF;
        seg_d = 7'h7F;
        if (state_q == S_OWN) begin
            an_d  = ~(4'b0001 << dig_q);
            seg_d = w_blank ? 7'h7F : hex7(w_nib);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            hold_q  <= '0;
            div_q   <= '0;
            dig_q   <= 2'd0;
            an_q    <= 4'hF;
            seg_q   <= 7'h7F;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            hold_q  <= hold_d;
            div_q   <= w_div_end ? '0 : div_q + 1'b1;
            if (w_div_end) dig_q <= dig_q + 2'd1;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign bus.gnt = (state_q == S_OWN) ? (NREQ'(1) << owner_q) : '0;
    assign bus.an  = an_q;
    assign bus.seg = seg_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
// ============================================================================
// Module      : tb_seg_display_arbiter
// Description : Directed bench for seg_display_arbiter with SCAN_DIV=4,
//               MIN_HOLD=2 (16-cycle frame).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_display_arbiter;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    seg_display_arbiter_if #(.NREQ(3)) bus ();

    seg_display_arbiter #(
        .NREQ     (3),
        .SCAN_DIV (4),
        .MIN_HOLD (2)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Assert reset at a falling edge and release it two cycles later, away from posedge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.req  = 3'b000;
        bus.data = '0;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        n_total++;
        if (bus.an !== 4'hF) begin n_bad++; $display("FAIL reset_an got=%h exp=%h", bus.an, 4'hF); end
        n_total++;
        if (bus.seg !== 7'h7F) begin n_bad++; $display("FAIL reset_seg got=%h exp=%h", bus.seg, 7'h7F); end
        n_total++;
        if (bus.gnt !== 3'b000) begin n_bad++; $display("FAIL reset_gnt got=%b exp=%b", bus.gnt, 3'b000); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_scan();
        logic [3:0] exp_an  [4];
        logic [6:0] exp_seg [4];
        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_seg = '{7'h0E, 7'h08, 7'h24, 7'h79};
        bus.req  = 3'b010;
        bus.data = {16'h0000, 16'h12AF, 16'h0000};
        do_reset();
        tick(15);
        n_total++;
        if (bus.gnt !== 3'b000) begin n_bad++; $display("FAIL single_pre_fb_gnt got=%b exp=%b", bus.gnt, 3'b000); end
        tick(1);
        n_total++;
        if (bus.gnt !== 3'b010) begin n_bad++; $display("FAIL single_gnt got=%b exp=%b", bus.gnt, 3'b010); end
        n_total++;
        if (bus.an !== 4'hF) begin n_bad++; $display("FAIL single_an_at_grant got=%b exp=%b", bus.an, 4'hF); end
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                tick(1);
                n_total++;
                if (bus.an !== exp_an[d] || bus.seg !== exp_seg[d]) begin
                    n_bad++;
                    $display("FAIL single_scan d=%0d c=%0d got an=%b seg=%h exp an=%b seg=%h",
                             d, c, bus.an, bus.seg, exp_an[d], exp_seg[d]);
                end
            end
        end
    endtask

    task automatic test_rotation();
        bus.req  = 3'b111;
        bus.data = {16'hBA98, 16'h7654, 16'h3210};
        do_reset();
        tick(16);
        n_total++;
        if (bus.gnt !== 3'b001) begin n_bad++; $display("FAIL rot_first got=%b exp=%b", bus.gnt, 3'b001); end
        tick(47);
        n_total++;
        if (bus.gnt !== 3'b001) begin n_bad++; $display("FAIL rot_hold0 got=%b exp=%b", bus.gnt, 3'b001); end
        tick(1);
        n_total++;
        if (bus.gnt !== 3'b010) begin n_bad++; $display("FAIL rot_to1 got=%b exp=%b", bus.gnt, 3'b010); end
        tick(1);
        n_total++;
        if (bus.an !== 4'b1110 || bus.seg !== 7'h19) begin
            n_bad++; $display("FAIL rot_disp1 got an=%b seg=%h exp an=1110 seg=19", bus.an, bus.seg);
        end
        tick(46);
        n_total++;
        if (bus.gnt !== 3'b010) begin n_bad++; $display("FAIL rot_hold1 got=%b exp=%b", bus.gnt, 3'b010); end
        tick(1);
        n_total++;
        if (bus.gnt !== 3'b100) begin n_bad++; $display("FAIL rot_to2 got=%b exp=%b", bus.gnt, 3'b100); end
        tick(47);
        n_total++;
        if (bus.gnt !== 3'b100) begin n_bad++; $display("FAIL rot_hold2 got=%b exp=%b", bus.gnt, 3'b100); end
        tick(1);
        n_total++;
        if (bus.gnt !== 3'b001) begin n_bad++; $display("FAIL rot_to0 got=%b exp=%b", bus.gnt, 3'b001); end
    endtask

    // Owner 1 drops mid-frame while client 2 waits; then client 2 drops as sole owner.
    task automatic test_drop();
        bus.req  = 3'b110;
        bus.data = {16'hBA98, 16'h12AF, 16'h0000};
        do_reset();
        tick(16);
        n_total++;
        if (bus.gnt !== 3'b010) begin n_bad++; $display("FAIL drop_grant1 got=%b exp=%b", bus.gnt, 3'b010); end
        tick(8);
        bus.req = 3'b100;
        tick(6);
        n_total++;
        if (bus.an !== 4'b0111 || bus.seg !== 7'h79) begin
            n_bad++; $display("FAIL drop_keep_disp got an=%b seg=%h exp an=0111 seg=79", bus.an, bus.seg);
        end
        tick(1);
        n_total++;
        if (bus.gnt !== 3'b010) begin n_bad++; $display("FAIL drop_gnt_before_fb got=%b exp=%b", bus.gnt, 3'b010); end
        tick(1);
        n_total++;
        if (bus.gnt !== 3'b100) begin n_bad++; $display("FAIL drop_handover got=%b exp=%b", bus.gnt, 3'b100); end
        tick(1);
        n_total++;
        if (bus.an !== 4'b1110 || bus.seg !== 7'h00) begin
            n_bad++; $display("FAIL drop_no_blank got an=%b seg=%h exp an=1110 seg=00", bus.an, bus.seg);
        end
        tick(7);
        bus.req = 3'b000;
        tick(8);
        n_total++;
        if (bus.gnt !== 3'b000) begin n_bad++; $display("FAIL idle_gnt got=%b exp=%b", bus.gnt, 3'b000); end
        n_total++;
        if (bus.an !== 4'b0111 || bus.seg !== 7'h03) begin
            n_bad++; $display("FAIL idle_last_digit got an=%b seg=%h exp an=0111 seg=03", bus.an, bus.seg);
        end
        tick(1);
        n_total++;
        if (bus.an !== 4'hF || bus.seg !== 7'h7F) begin
            n_bad++; $display("FAIL idle_blank got an=%b seg=%h exp an=1111 seg=7f", bus.an, bus.seg);
        end
    endtask

    // Continues from the idle state left by test_drop (next boundary 15 cycles away).
    task automatic test_reset_mid_scan();
        bus.req  = 3'b001;
        bus.data = {16'h0000, 16'h0000, 16'h0042};
        tick(15);
        n_total++;
        if (bus.gnt !== 3'b001) begin n_bad++; $display("FAIL mid_pre_grant got=%b exp=%b", bus.gnt, 3'b001); end
        tick(6);
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.gnt !== 3'b000) begin
            n_bad++; $display("FAIL mid_async_blank got an=%b seg=%h gnt=%b exp an=1111 seg=7f gnt=000",
                              bus.an, bus.seg, bus.gnt);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick(15);
        n_total++;
        if (bus.gnt !== 3'b000) begin n_bad++; $display("FAIL mid_restart_early got=%b exp=%b", bus.gnt, 3'b000); end
        tick(1);
        n_total++;
        if (bus.gnt !== 3'b001) begin n_bad++; $display("FAIL mid_restart_grant got=%b exp=%b", bus.gnt, 3'b001); end
    endtask

    // Runs right after the regrant in test_reset_mid_scan with data0 = 0x0042.
    task automatic test_leading_blank();
        logic [3:0] exp_an  [4];
        logic [6:0] exp_seg [4];
        exp_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
`ifdef SEG_BLANK_LEADING_EN
        exp_seg = '{7'h24, 7'h19, 7'h7F, 7'h7F};
`else
        exp_seg = '{7'h24, 7'h19, 7'h40, 7'h40};
`endif
        for (int d = 0; d < 4; d++) begin
            tick((d == 0) ? 1 : 4);
            n_total++;
            if (bus.an !== exp_an[d] || bus.seg !== exp_seg[d]) begin
                n_bad++;
                $display("FAIL blank_digit d=%0d got an=%b seg=%h exp an=%b seg=%h",
                         d, bus.an, bus.seg, exp_an[d], exp_seg[d]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total  = 0;
        n_bad    = 0;
        rst_n    = 1'b1;
        bus.req  = '0;
        bus.data = '0;
        test_reset();
        test_single_scan();
        test_rotation();
        test_drop();
        test_reset_mid_scan();
        test_leading_blank();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
